ospi_ctrl: RTL and testbench

OSPI_CTRL -- requirements
Module: ospi_ctrl

---
 rtl/ospi_pkg.sv | 37 +++
 rtl/ospi_sclk_gen.sv | 30 +++
 rtl/ospi_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_ospi_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ospi_pkg.sv
// Shared definitions for the octal SPI controller: host op encoding, flash
// command bytes and the controller state encoding.
package ospi_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_ERASE   = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_ERASE = 8'h20;
  localparam logic [7:0] CMD_WREN  = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_DATA   = 3'd4,
    ST_CSHIGH = 3'd5,
    ST_RESP   = 3'd6
  } state_e;

  // Flash command byte for a legal host op.
  function automatic logic [7:0] cmd_byte(input op_e op);
    case (op)
      OP_READ:  cmd_byte = CMD_READ;
      OP_WRITE: cmd_byte = CMD_WRITE;
      OP_ERASE: cmd_byte = CMD_ERASE;
      default:  cmd_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ospi_sclk_gen.sv
// OSPI serial clock generator: while i_run is high the bus clock runs at
// clk/2, starting with a low phase; otherwise it is held low and the phase
// restarts so every frame begins low.
module ospi_sclk_gen (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  output logic o_sclk,
  output logic o_phase_low,
  output logic o_phase_high
);

  logic r_phase;

  // Toggle the phase every clk while running, restart low when stopped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= 1'b0;
    end else if (i_run) begin
      r_phase <= ~r_phase;
    end else begin
      r_phase <= 1'b0;
    end
  end

  assign o_sclk       = i_run & r_phase;
  assign o_phase_low  = i_run & ~r_phase;
  assign o_phase_high = i_run & r_phase;

endmodule

// File: rtl/ospi_ctrl.sv
// Single-byte octal SPI flash controller (READ / WRITE / ERASE).
// Optional feature macro: OSPI_CTRL_WREN_EN -- when defined, WRITE and ERASE
// are preceded by a command-only write-enable (0x06) frame and a 2-clk
// chip-select-high gap.
// Handshake: a request is taken on the rising clk edge where
// req_valid && req_ready; req_ready is high only in IDLE. rsp_valid is a
// one-cycle pulse with no back-pressure.
module ospi_ctrl
  import ospi_pkg::*;
#(
  parameter int DUMMY_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       ospi_clk,
  output logic       ospi_cs_n,
  output logic [7:0] ospi_io_out,
  output logic       ospi_io_oe,
  input  logic [7:0] ospi_io_in,
  output logic [2:0] dbg_state
);

  localparam logic [3:0] DUMMY_LAST = 4'((DUMMY_CYCLES == 0) ? 0 : DUMMY_CYCLES - 1);

  state_e     r_state;
  state_e     w_next;
  op_e        r_op;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rx;
  logic [7:0] r_rdata;
  logic [3:0] r_dummy_cnt;
  logic       r_cs_cnt;
  logic       w_run;
  logic       w_low;
  logic       w_high;
  logic       w_accept;
  logic       w_wren;

  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_run    = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                    (r_state == ST_DUMMY) || (r_state == ST_DATA);

  ospi_sclk_gen u_sclk (
    .i_clk        (clk),
    .i_rst_n      (reset_n),
    .i_run        (w_run),
    .o_sclk       (ospi_clk),
    .o_phase_low  (w_low),
    .o_phase_high (w_high)
  );

`ifdef OSPI_CTRL_WREN_EN
  logic r_wren;

  // Marks the write-enable pre-frame; cleared as its CS-high gap ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wren <= 1'b0;
    end else if (w_accept) begin
      r_wren <= (req_op == OP_WRITE) || (req_op == OP_ERASE);
    end else if ((r_state == ST_CSHIGH) && r_cs_cnt) begin
      r_wren <= 1'b0;
    end
  end

  assign w_wren = r_wren;
`else
  assign w_wren = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Phase counters: dummy cycles completed and position inside CS-high gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dummy_cnt <= 4'd0;
      r_cs_cnt    <= 1'b0;
    end else begin
      if (r_state != ST_DUMMY) begin
        r_dummy_cnt <= 4'd0;
      end else if (w_high) begin
        r_dummy_cnt <= r_dummy_cnt + 4'd1;
      end
      r_cs_cnt <= (r_state == ST_CSHIGH) ? ~r_cs_cnt : 1'b0;
    end
  end

  // Request capture, read sampling on the sclk rising edge, and transfer of
  // the sampled byte to the response register as the data phase ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op    <= OP_READ;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
      r_rx    <= 8'h00;
      r_rdata <= 8'h00;
    end else begin
      if (w_accept) begin
        r_op    <= op_e'(req_op);
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if ((r_state == ST_DATA) && (r_op == OP_READ) && w_low) begin
        r_rx <= ospi_io_in;
      end
      if ((r_state == ST_DATA) && (r_op == OP_READ) && w_high) begin
        r_rdata <= r_rx;
      end
    end
  end

  // Next-state logic; bus phases advance at the end of the sclk-high cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_next = (req_op == OP_ILLEGAL) ? ST_RESP : ST_CMD;
        end
      end
      ST_CMD: begin
        if (w_high) begin
          w_next = w_wren ? ST_CSHIGH : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (w_high) begin
          case (r_op)
            OP_READ:  w_next = (DUMMY_CYCLES == 0) ? ST_DATA : ST_DUMMY;
            OP_WRITE: w_next = ST_DATA;
            default:  w_next = ST_CSHIGH;
          endcase
        end
      end
      ST_DUMMY: begin
        if (w_high && (r_dummy_cnt == DUMMY_LAST)) begin
          w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_high) begin
          w_next = ST_CSHIGH;
        end
      end
      ST_CSHIGH: begin
        if (r_cs_cnt) begin
          w_next = w_wren ? ST_CMD : ST_IDLE;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    ospi_cs_n   = ~w_run;
    ospi_io_oe  = 1'b0;
    ospi_io_out = 8'h00;
    case (r_state)
      ST_CMD: begin
        ospi_io_oe  = 1'b1;
        ospi_io_out = w_wren ? CMD_WREN : cmd_byte(r_op);
      end
      ST_ADDR: begin
        ospi_io_oe  = 1'b1;
        ospi_io_out = r_addr;
      end
      ST_DATA: begin
        if (r_op == OP_WRITE) begin
          ospi_io_oe  = 1'b1;
          ospi_io_out = r_wdata;
        end
      end
      default: begin
        ospi_io_oe  = 1'b0;
        ospi_io_out = 8'h00;
      end
    endcase
    req_ready = (r_state == ST_IDLE);
    rsp_valid = ((r_state == ST_CSHIGH) && !r_cs_cnt && !w_wren) || (r_state == ST_RESP);
    rsp_err   = (r_state == ST_RESP);
    rsp_rdata = r_rdata;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_ospi_ctrl.sv
// Bench for ospi_ctrl: main instance with 4 dummy cycles, second instance
// with 0 dummy cycles for the back-to-back read case.
module tb_ospi_ctrl;

  localparam int D = 4;
  localparam int W = 19;  // {ready_delay[1:0], latency[7:0], err, rdata[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT ----------------
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       ospi_clk;
  logic       ospi_cs_n;
  logic [7:0] ospi_io_out;
  logic       ospi_io_oe;
  logic [7:0] ospi_io_in;
  logic [2:0] dbg_state;

  ospi_ctrl #(.DUMMY_CYCLES(D)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ospi_clk(ospi_clk), .ospi_cs_n(ospi_cs_n), .ospi_io_out(ospi_io_out),
    .ospi_io_oe(ospi_io_oe), .ospi_io_in(ospi_io_in), .dbg_state(dbg_state)
  );

  // ---------------- zero-dummy DUT ----------------
  logic       req_valid0 = 1'b0;
  logic       req_ready0;
  logic [1:0] req_op0 = 2'b00;
  logic [7:0] req_addr0 = 8'h22;
  logic [7:0] req_wdata0 = 8'h00;
  logic       rsp_valid0;
  logic [7:0] rsp_rdata0;
  logic       rsp_err0;
  logic       ospi_clk0;
  logic       ospi_cs_n0;
  logic [7:0] ospi_io_out0;
  logic       ospi_io_oe0;
  logic [7:0] ospi_io_in0;
  logic [2:0] dbg_state0;

  ospi_ctrl #(.DUMMY_CYCLES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_op(req_op0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .ospi_clk(ospi_clk0), .ospi_cs_n(ospi_cs_n0), .ospi_io_out(ospi_io_out0),
    .ospi_io_oe(ospi_io_oe0), .ospi_io_in(ospi_io_in0), .dbg_state(dbg_state0)
  );

  // ---------------- flash models ----------------
  // Data byte is presented only in the low phase after CMD, ADDR and all
  // dummy rising edges, so a mistimed sample reads 0x00.
  logic [7:0] flash_byte = 8'h00;
  int rise_cnt = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rise_cnt <= 0;
    else if (ospi_cs_n) rise_cnt <= 0;
    else if (ospi_clk) rise_cnt <= rise_cnt + 1;
  end
  assign ospi_io_in = (!ospi_cs_n && rise_cnt == 2 + D) ? flash_byte : 8'h00;

  int rise0 = 0;
  int frm0 = 0;
  logic prev_cs0 = 1'b1;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise0 <= 0; frm0 <= 0; prev_cs0 <= 1'b1;
    end else begin
      prev_cs0 <= ospi_cs_n0;
      if (ospi_cs_n0 && !prev_cs0) frm0 <= frm0 + 1;
      if (ospi_cs_n0) rise0 <= 0;
      else if (ospi_clk0) rise0 <= rise0 + 1;
    end
  end
  assign ospi_io_in0 = (!ospi_cs_n0 && rise0 == 2) ? ((frm0 == 0) ? 8'h5A : 8'hC3) : 8'h00;

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  logic [8:0]   beat_q[$];   // {oe, byte}
  int           frame_q[$];  // cs_n low cycles per frame
  logic [39:0]  exp0_q[$];   // {negedge cycle, rdata}
  logic [7:0]   last_rd = 8'h00;
  int           rdy_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic [1:0] op, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] rd);
    int t;
    int lat;
    logic wren;
    logic [1:0] rdy;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      check("accept_timeout", 32'(t), 32'd0);
      req_valid = 1'b0;
      return;
    end
`ifdef OSPI_CTRL_WREN_EN
    wren = (op == 2'b01) || (op == 2'b10);
`else
    wren = 1'b0;
`endif
    if (wren) begin
      frame_q.push_back(2);
      beat_q.push_back({1'b1, 8'h06});
    end
    rdy = 2'd2;
    case (op)
      2'b00: begin
        lat = 2 * D + 7;
        frame_q.push_back(2 * D + 6);
        beat_q.push_back({1'b1, 8'h0B});
        beat_q.push_back({1'b1, addr});
        for (int i = 0; i < D + 1; i++) beat_q.push_back({1'b0, 8'h00});
        flash_byte = rd;
        last_rd = rd;
      end
      2'b01: begin
        lat = 7;
        frame_q.push_back(6);
        beat_q.push_back({1'b1, 8'h02});
        beat_q.push_back({1'b1, addr});
        beat_q.push_back({1'b1, wdata});
      end
      2'b10: begin
        lat = 5;
        frame_q.push_back(4);
        beat_q.push_back({1'b1, 8'h20});
        beat_q.push_back({1'b1, addr});
      end
      default: begin
        lat = 1;
        rdy = 2'd1;
      end
    endcase
    if (wren) lat += 4;
    exp_q.push_back({rdy, 8'(lat), (op == 2'b11), last_rd});
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
    req_valid = 1'b0;
    req_op = 2'($urandom_range(0, 3));
    req_addr = 8'($urandom_range(0, 255));
    req_wdata = 8'($urandom_range(0, 255));
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() + beat_q.size() + frame_q.size() + rdy_left) != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", 32'(exp_q.size() + beat_q.size() + frame_q.size()), 32'd0);
  endtask

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    int a;
    if (reset_n) begin
      if (rdy_left > 0) begin
        rdy_left--;
        check("ready_after_rsp", 32'(req_ready), 32'(rdy_left == 0));
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(e[7:0]));
          check("rsp_err", 32'(rsp_err), 32'(e[8]));
          check("rsp_latency", 32'(cyc - a + 1), 32'(e[16:9]));
          check("cs_high_at_rsp", 32'(ospi_cs_n), 32'd1);
          rdy_left = int'(e[18:17]);
        end
      end
    end
  end

  // ---------------- bus monitor ----------------
  logic [7:0] low_io = 8'h00;
  int lo_cnt = 0;
  logic prev_cs = 1'b1;
  always @(negedge clk) begin
    logic [8:0] b;
    if (!reset_n) begin
      lo_cnt = 0;
      prev_cs = 1'b1;
    end else begin
      if (!ospi_cs_n) lo_cnt++;
      if (ospi_cs_n && !prev_cs) begin
        if (frame_q.size() == 0) check("frame_unexpected", 32'(lo_cnt), 32'd0);
        else check("cs_low_cycles", 32'(lo_cnt), 32'(frame_q.pop_front()));
        lo_cnt = 0;
      end
      if (!ospi_cs_n && !ospi_clk) low_io = ospi_io_out;
      if (ospi_clk) begin
        if (beat_q.size() == 0) begin
          check("beat_unexpected", 32'(ospi_clk), 32'd0);
        end else begin
          b = beat_q.pop_front();
          check("beat_oe", 32'(ospi_io_oe), 32'(b[8]));
          if (b[8]) begin
            check("beat_byte", 32'(ospi_io_out), 32'(b[7:0]));
            check("io_stable_high", 32'(ospi_io_out), 32'(low_io));
          end
        end
      end
      prev_cs = ospi_cs_n;
    end
  end

  // ---------------- zero-dummy monitor ----------------
  always @(negedge clk) begin
    logic [39:0] e;
    if (reset_n && rsp_valid0) begin
      if (exp0_q.size() == 0) begin
        check("d0_rsp_unexpected", 32'(rsp_valid0), 32'd0);
      end else begin
        e = exp0_q.pop_front();
        check("d0_rsp_cycle", 32'(cyc), e[39:8]);
        check("d0_rsp_rdata", 32'(rsp_rdata0), 32'(e[7:0]));
        check("d0_rsp_err", 32'(rsp_err0), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int s;
    int t;
    #2 reset_n = 1'b0;
    #1;
    check("rst_cs_n", 32'(ospi_cs_n), 32'd1);
    check("rst_sclk", 32'(ospi_clk), 32'd0);
    check("rst_oe", 32'(ospi_io_oe), 32'd0);
    check("rst_io_out", 32'(ospi_io_out), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // Zero-dummy instance: valid held high across two reads.
    @(negedge clk);
    s = cyc;
    req_valid0 = 1'b1;
    exp0_q.push_back({32'(s + 7), 8'h5A});
    exp0_q.push_back({32'(s + 16), 8'hC3});
    while (cyc < s + 9) begin
      @(negedge clk);
      if (cyc == s + 8) check("d0_ready_in_cshigh", 32'(req_ready0), 32'd0);
      if (cyc == s + 9) check("d0_ready_after_cshigh", 32'(req_ready0), 32'd1);
    end
    @(posedge clk);
    #1 req_valid0 = 1'b0;
    t = 0;
    while (exp0_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("d0_drain", 32'(exp0_q.size()), 32'd0);

    // Directed main sequence.
    issue(2'b00, 8'h01, 8'h00, 8'hA5);
    drain();
    issue(2'b01, 8'h10, 8'h3C, 8'h00);
    drain();
    issue(2'b10, 8'h80, 8'h00, 8'h00);
    drain();
    issue(2'b11, 8'h55, 8'h77, 8'h00);
    drain();
    issue(2'b00, 8'h7F, 8'h00, 8'h3C);
    issue(2'b01, 8'hFF, 8'h00, 8'h00);
    issue(2'b00, 8'h00, 8'h00, 8'hFF);
    drain();

    // Reset during the dummy phase of a read.
    issue(2'b00, 8'h44, 8'h00, 8'h99);
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    exp_q.delete(); acc_q.delete(); beat_q.delete(); frame_q.delete();
    rdy_left = 0;
    last_rd = 8'h00;
    #1;
    check("midrst_cs_n", 32'(ospi_cs_n), 32'd1);
    check("midrst_oe", 32'(ospi_io_oe), 32'd0);
    check("midrst_sclk", 32'(ospi_clk), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_midrst", 32'(req_ready), 32'd1);
    issue(2'b00, 8'h33, 8'h00, 8'h81);
    drain();
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
